// File: rtl/pulse_width_monitor.sv
// pulse_width_monitor
// Measures high width, low width and period of a pulse stream in clk cycles,
// checks the high width against programmable bounds, and cross-checks every
// pulse toggle against the generator's pulse_active strobe.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | monitor disabled, counters held, no sync check
// S_ARM  | waiting for the first edge; partial level in progress discarded
// S_HIGH | timing a high level, run_cnt = cycles high so far
// S_LOW  | timing a low level, run_cnt = cycles low so far
module pulse_width_monitor #(
    parameter int WIDTH_BITS = 8,
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  pulse_in,
    input  logic                  pulse_active_in,
    input  logic [WIDTH_BITS-1:0] min_width,
    input  logic [WIDTH_BITS-1:0] max_width,
    output logic [WIDTH_BITS-1:0] high_width,
    output logic [WIDTH_BITS-1:0] low_width,
    output logic [WIDTH_BITS:0]   period,
    output logic                  high_valid,
    output logic                  period_valid,
    output logic [COUNT_BITS-1:0] pulse_count,
    output logic                  too_short,
    output logic                  too_long,
    output logic                  stuck,
    output logic                  sync_err
);

    localparam logic [WIDTH_BITS-1:0] RUN_MAX   = '1;
    localparam logic [WIDTH_BITS-1:0] RUN_ONE   = WIDTH_BITS'(1);
    localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_BITS-1:0] COUNT_ONE = COUNT_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                  pulse_q;
    logic                  pulse_edge;
    logic                  rise;
    logic                  fall;
    logic                  run_sat;
    logic [WIDTH_BITS-1:0] run_cnt;
    logic                  have_high;

    // control strobes produced by the FSM for the datapath
    logic cnt_load;
    logic cnt_inc;
    logic cap_high;
    logic cap_low;
    logic cap_period;
    logic drop_high;
    logic set_stuck;
    logic sync_chk;

    assign pulse_edge = pulse_in ^ pulse_q;
    assign rise       = pulse_edge & pulse_in;
    assign fall       = pulse_edge & ~pulse_in;
    assign run_sat    = (run_cnt == RUN_MAX);

    // input history for edge detection, updated in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_in;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state and datapath control; clear beats enable beats edge beats saturation
    always_comb begin
        state_nxt  = state;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        cap_high   = 1'b0;
        cap_low    = 1'b0;
        cap_period = 1'b0;
        drop_high  = 1'b0;
        set_stuck  = 1'b0;
        sync_chk   = (state != S_IDLE) && !clear;

        if (clear) begin
            state_nxt = enable ? S_ARM : S_IDLE;
        end else if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_ARM;
                end
                S_ARM: begin
                    if (rise) begin
                        state_nxt = S_HIGH;
                        cnt_load  = 1'b1;
                        drop_high = 1'b1;
                    end else if (fall) begin
                        state_nxt = S_LOW;
                        cnt_load  = 1'b1;
                        drop_high = 1'b1;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        state_nxt = S_LOW;
                        cap_high  = 1'b1;
                        cnt_load  = 1'b1;
                    end else if (run_sat) begin
                        state_nxt = S_ARM;
                        set_stuck = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        state_nxt  = S_HIGH;
                        cap_low    = 1'b1;
                        cap_period = have_high;
                        cnt_load   = 1'b1;
                    end else if (run_sat) begin
                        state_nxt = S_ARM;
                        set_stuck = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // run-length counter; the edge cycle itself is the first cycle of the new level
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (cnt_load) begin
            run_cnt <= RUN_ONE;
        end else if (cnt_inc) begin
            run_cnt <= run_cnt + RUN_ONE;
        end
    end

    // remembers whether this measurement chain already holds a valid high width
    always_ff @(posedge clk) begin
        if (rst) begin
            have_high <= 1'b0;
        end else if (drop_high) begin
            have_high <= 1'b0;
        end else if (cap_high) begin
            have_high <= 1'b1;
        end
    end

    // captured widths and their one-cycle valid strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            high_width   <= '0;
            low_width    <= '0;
            period       <= '0;
            high_valid   <= 1'b0;
            period_valid <= 1'b0;
        end else begin
            high_valid   <= cap_high;
            period_valid <= cap_period;
            if (cap_high) begin
                high_width <= run_cnt;
            end
            if (cap_low) begin
                low_width <= run_cnt;
            end
            if (cap_period) begin
                period <= {1'b0, high_width} + {1'b0, run_cnt};
            end
        end
    end

    // saturating count of completed high pulses
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pulse_count <= '0;
        end else if (cap_high && (pulse_count != COUNT_MAX)) begin
            pulse_count <= pulse_count + COUNT_ONE;
        end
    end

    // sticky status flags, only cleared by rst or clear
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            too_short <= 1'b0;
            too_long  <= 1'b0;
            stuck     <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            if (cap_high && (run_cnt < min_width)) begin
                too_short <= 1'b1;
            end
            if (cap_high && (run_cnt > max_width)) begin
                too_long <= 1'b1;
            end
            if (set_stuck) begin
                stuck <= 1'b1;
            end
            if (sync_chk && (pulse_edge ^ pulse_active_in)) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_monitor.sv
// Testbench for pulse_width_monitor: a directed vector table, hand-written
// corner sequences and a randomized run, all checked against a timestamp
// based reference model of the measurement rules.
module tb_pulse_width_monitor;

    localparam int WB   = 8;
    localparam int CB   = 16;
    localparam int MAXW = (1 << WB) - 1;
    localparam int MAXC = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          rst, enable, clear, pulse_in, pulse_active_in;
    logic [WB-1:0] min_width, max_width;
    logic [WB-1:0] high_width, low_width;
    logic [WB:0]   period;
    logic          high_valid, period_valid;
    logic [CB-1:0] pulse_count;
    logic          too_short, too_long, stuck, sync_err;

    always #5 clk = ~clk;

    pulse_width_monitor #(.WIDTH_BITS(WB), .COUNT_BITS(CB)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .clear           (clear),
        .pulse_in        (pulse_in),
        .pulse_active_in (pulse_active_in),
        .min_width       (min_width),
        .max_width       (max_width),
        .high_width      (high_width),
        .low_width       (low_width),
        .period          (period),
        .high_valid      (high_valid),
        .period_valid    (period_valid),
        .pulse_count     (pulse_count),
        .too_short       (too_short),
        .too_long        (too_long),
        .stuck           (stuck),
        .sync_err        (sync_err)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: measures levels as the distance between edge timestamps
    typedef enum int {M_IDLE, M_ARMED, M_MEAS} mmode_t;
    mmode_t m_mode = M_IDLE;
    int m_cyc = 0, m_start = 0;
    bit m_pq = 0, m_have_high = 0;
    int m_hw = 0, m_lw = 0, m_per = 0, m_cnt = 0;
    bit m_hv = 0, m_pv = 0, m_short = 0, m_long = 0, m_stuck = 0, m_serr = 0;

    task automatic model_step(input bit r, input bit en, input bit cl, input bit p,
                              input bit pa, input int mn, input int mx);
        bit e;
        int w;
        e    = p ^ m_pq;
        m_hv = 0;
        m_pv = 0;
        if (r) begin
            m_mode = M_IDLE; m_have_high = 0;
            m_hw = 0; m_lw = 0; m_per = 0; m_cnt = 0;
            m_short = 0; m_long = 0; m_stuck = 0; m_serr = 0;
        end else if (cl) begin
            m_short = 0; m_long = 0; m_stuck = 0; m_serr = 0; m_cnt = 0;
            m_mode = en ? M_ARMED : M_IDLE;
        end else begin
            if (m_mode != M_IDLE && (e != pa)) m_serr = 1;
            if (!en) begin
                m_mode = M_IDLE;
            end else begin
                case (m_mode)
                    M_IDLE: m_mode = M_ARMED;
                    M_ARMED: begin
                        if (e) begin
                            m_mode = M_MEAS; m_start = m_cyc; m_have_high = 0;
                        end
                    end
                    M_MEAS: begin
                        w = m_cyc - m_start;
                        if (e && !p) begin
                            m_hw = w; m_hv = 1;
                            if (w < mn) m_short = 1;
                            if (w > mx) m_long = 1;
                            if (m_cnt < MAXC) m_cnt++;
                            m_have_high = 1; m_start = m_cyc;
                        end else if (e && p) begin
                            m_lw = w;
                            if (m_have_high) begin
                                m_per = m_hw + w; m_pv = 1;
                            end
                            m_start = m_cyc;
                        end else if (w >= MAXW) begin
                            m_stuck = 1; m_mode = M_ARMED;
                        end
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
        end
        m_pq = r ? 1'b0 : p;
        m_cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model.high_width",   32'(high_width),   32'(m_hw));
        chk("model.low_width",    32'(low_width),    32'(m_lw));
        chk("model.period",       32'(period),       32'(m_per));
        chk("model.high_valid",   32'(high_valid),   32'(m_hv));
        chk("model.period_valid", 32'(period_valid), 32'(m_pv));
        chk("model.pulse_count",  32'(pulse_count),  32'(m_cnt));
        chk("model.too_short",    32'(too_short),    32'(m_short));
        chk("model.too_long",     32'(too_long),     32'(m_long));
        chk("model.stuck",        32'(stuck),        32'(m_stuck));
        chk("model.sync_err",     32'(sync_err),     32'(m_serr));
    endtask

    // drive one cycle of inputs, advance the model, sample after the edge
    task automatic step(input bit r, input bit en, input bit cl, input bit p, input bit pa);
        @(negedge clk);
        rst = r; enable = en; clear = cl; pulse_in = p; pulse_active_in = pa;
        model_step(r, en, cl, p, pa, int'(min_width), int'(max_width));
        @(posedge clk);
        #1;
        compare_model();
    endtask

    typedef struct {
        bit r, en, cl, p, pa;
        bit hv, pv;
        int hw, lw, per, cnt;
        bit [3:0] fl;   // {too_short, too_long, stuck, sync_err}
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit r, input bit en, input bit cl, input bit p,
                                input bit pa, input bit hv, input bit pv, input int hw,
                                input int lw, input int per, input int cnt, input bit [3:0] fl);
        vec_t v;
        v.r = r; v.en = en; v.cl = cl; v.p = p; v.pa = pa;
        v.hv = hv; v.pv = pv; v.hw = hw; v.lw = lw; v.per = per; v.cnt = cnt; v.fl = fl;
        tbl.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; pulse_in = 1'b0; pulse_active_in = 1'b0;
        min_width = WB'(2); max_width = WB'(4);

        //  r en cl p pa   hv pv hw lw per cnt flags
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4'b0000);
        add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4'b0000);
        add(0, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 4'b0000);
        add(0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 4'b0000);
        add(0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 4'b0000);
        add(0, 1, 0, 0, 1,  1, 0, 3, 0, 0, 1, 4'b0000);
        add(0, 1, 0, 0, 0,  0, 0, 3, 0, 0, 1, 4'b0000);
        add(0, 1, 0, 0, 0,  0, 0, 3, 0, 0, 1, 4'b0000);
        add(0, 1, 0, 1, 1,  0, 1, 3, 3, 6, 1, 4'b0000);
        add(0, 1, 0, 1, 0,  0, 0, 3, 3, 6, 1, 4'b0000);
        add(0, 1, 0, 1, 0,  0, 0, 3, 3, 6, 1, 4'b0000);
        add(0, 1, 0, 0, 1,  1, 0, 3, 3, 6, 2, 4'b0000);
        add(0, 1, 0, 1, 1,  0, 1, 3, 1, 4, 2, 4'b0000);
        add(0, 1, 0, 0, 1,  1, 0, 1, 1, 4, 3, 4'b1000);
        add(0, 1, 0, 0, 0,  0, 0, 1, 1, 4, 3, 4'b1000);
        add(0, 1, 0, 1, 1,  0, 1, 1, 2, 3, 3, 4'b1000);
        add(0, 1, 0, 1, 0,  0, 0, 1, 2, 3, 3, 4'b1000);
        add(0, 1, 0, 1, 0,  0, 0, 1, 2, 3, 3, 4'b1000);
        add(0, 1, 0, 1, 0,  0, 0, 1, 2, 3, 3, 4'b1000);
        add(0, 1, 0, 1, 0,  0, 0, 1, 2, 3, 3, 4'b1000);
        add(0, 1, 0, 0, 1,  1, 0, 5, 2, 3, 4, 4'b1100);
        add(0, 1, 1, 0, 0,  0, 0, 5, 2, 3, 0, 4'b0000);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].en, tbl[i].cl, tbl[i].p, tbl[i].pa);
            chk($sformatf("tbl[%0d].high_valid", i), 32'(high_valid), 32'(tbl[i].hv));
            chk($sformatf("tbl[%0d].period_valid", i), 32'(period_valid), 32'(tbl[i].pv));
            chk($sformatf("tbl[%0d].high_width", i), 32'(high_width), 32'(tbl[i].hw));
            chk($sformatf("tbl[%0d].low_width", i), 32'(low_width), 32'(tbl[i].lw));
            chk($sformatf("tbl[%0d].period", i), 32'(period), 32'(tbl[i].per));
            chk($sformatf("tbl[%0d].pulse_count", i), 32'(pulse_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl[%0d].flags", i),
                32'({too_short, too_long, stuck, sync_err}), 32'(tbl[i].fl));
        end

        // high held 256 cycles: saturates, no capture, FSM back in ARM
        step(0, 1, 0, 1, 1);
        repeat (254) step(0, 1, 0, 1, 0);
        chk("sat.stuck_before", 32'(stuck), 32'd0);
        step(0, 1, 0, 1, 0);
        chk("sat.stuck_set", 32'(stuck), 32'd1);
        chk("sat.no_high_valid", 32'(high_valid), 32'd0);
        step(0, 1, 0, 0, 1);
        chk("sat.arm_fall_no_capture", 32'(high_valid), 32'd0);
        chk("sat.high_width_kept", 32'(high_width), 32'd5);

        // fall exactly 255 cycles after rise: normal capture of MAX
        step(0, 1, 1, 0, 0);
        chk("max.stuck_cleared", 32'(stuck), 32'd0);
        step(0, 1, 0, 1, 1);
        repeat (254) step(0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 1);
        chk("max.high_width", 32'(high_width), 32'd255);
        chk("max.high_valid", 32'(high_valid), 32'd1);
        chk("max.stuck", 32'(stuck), 32'd0);
        chk("max.too_long", 32'(too_long), 32'd1);

        // sync check: toggle without strobe, then strobe without toggle
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 1, 0);
        chk("sync.toggle_no_strobe", 32'(sync_err), 32'd1);
        step(0, 1, 1, 1, 0);
        chk("sync.cleared", 32'(sync_err), 32'd0);
        step(0, 1, 0, 1, 1);
        chk("sync.strobe_no_toggle", 32'(sync_err), 32'd1);

        // clear coincident with a fall in HIGH
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 1, 1);
        chk("clr.no_period_without_high", 32'(period_valid), 32'd0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 1);
        chk("clr.no_high_valid", 32'(high_valid), 32'd0);
        chk("clr.pulse_count", 32'(pulse_count), 32'd0);
        chk("clr.flags", 32'({too_short, too_long, stuck, sync_err}), 32'd0);
        step(0, 1, 0, 1, 1);
        chk("clr.fresh_rise_no_period", 32'(period_valid), 32'd0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 1);
        chk("clr.high_width", 32'(high_width), 32'd2);
        chk("clr.pulse_count_after", 32'(pulse_count), 32'd1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 1);
        chk("clr.period_valid", 32'(period_valid), 32'd1);
        chk("clr.period", 32'(period), 32'd4);

        // reset mid-HIGH with a sticky flag set, then disabled toggling
        step(0, 1, 0, 1, 1);
        chk("rst.flag_pre", 32'(sync_err), 32'd1);
        step(1, 1, 0, 1, 0);
        chk("rst.all_zero",
            32'({high_width, low_width, high_valid, period_valid, too_short, too_long,
                 stuck, sync_err}), 32'd0);
        chk("rst.period_zero", 32'(period), 32'd0);
        chk("rst.count_zero", 32'(pulse_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, i[0], 1'b0);
            chk("dis.strobes", 32'({high_valid, period_valid}), 32'd0);
            chk("dis.sync_err", 32'(sync_err), 32'd0);
        end

        // randomized traffic against the model
        begin
            bit en_cur = 1'b1;
            bit p_cur  = 1'b0;
            int rem    = 3;
            step(1, 1, 0, 0, 0);
            for (int i = 0; i < 4000; i++) begin
                bit r, cl, pa, glitch;
                int mn;
                if ($urandom_range(0, 99) == 0) begin
                    mn = int'($urandom_range(1, 4));
                    min_width = WB'(mn);
                    max_width = WB'(mn + int'($urandom_range(0, 4)));
                end
                if ($urandom_range(0, 149) == 0) en_cur = !en_cur;
                r  = ($urandom_range(0, 499) == 0);
                cl = ($urandom_range(0, 79) == 0);
                if (rem == 0) begin
                    p_cur = !p_cur;
                    rem = ($urandom_range(0, 39) == 0) ? int'($urandom_range(250, 258))
                                                       : int'($urandom_range(1, 7));
                end
                rem--;
                glitch = ($urandom_range(0, 49) == 0);
                pa = (p_cur ^ m_pq) ^ glitch;
                step(r, en_cur, cl, p_cur, pa);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
